// File: rtl/wb_i2c_pkg.sv
// Shared definitions for the Wishbone-to-I2C command bridge: register
// offsets, CTRL/STATUS bit positions and FSM state encoding.
package wb_i2c_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_ADDR   = 3'd1;
    localparam logic [2:0] OFF_REG    = 3'd2;
    localparam logic [2:0] OFF_TXDATA = 3'd3;
    localparam logic [2:0] OFF_RXDATA = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;

    localparam int CTRL_GO = 0;
    localparam int CTRL_RW = 1;
    localparam int CTRL_IE = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_NACK = 2;
    localparam int ST_TMO  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/wb_i2c_ctrl_if.sv
// Wishbone classic slave bus as seen by the I2C command bridge.
interface wb_i2c_ctrl_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport slave  (input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                    output wb_dat_o, wb_ack_o);
    modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
                    input  wb_dat_o, wb_ack_o);
endinterface

// File: rtl/wb_i2c_ctrl.sv
// Wishbone register front-end that sequences one I2C master transaction per
// GO, with minimum start-high spacing, timeout abort and sticky status.
module wb_i2c_ctrl
    import wb_i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 32'd200000,
    parameter int unsigned MIN_IDLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    wb_i2c_ctrl_if.slave wb,
    output logic       i2c_start,
    output logic       i2c_rw,
    output logic [6:0] i2c_slave_address,
    output logic [7:0] i2c_slave_reg,
    output logic [7:0] i2c_tx_data,
    input  logic       i2c_done,
    input  logic       i2c_ack,
    input  logic [7:0] i2c_rx_data,
    input  logic       i2c_busy,
    output logic       irq
);

    state_e      state_q, state_d;
    logic        rw_q, rw_d, ie_q, ie_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  reg_q, reg_d, tx_q, tx_d, rx_q, rx_d;
    logic        done_q, done_d, nack_q, nack_d, tmo_q, tmo_d;
    logic [31:0] idle_cnt_q, idle_cnt_d, tcnt_q, tcnt_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d, rdata;

    logic [2:0]  sel;
    logic        req, wr, busy, go, fin_done, fin_tmo;

    assign sel      = wb.wb_adr_i[4:2];
    assign req      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr       = req & wb.wb_we_i;
    assign busy     = (state_q != S_IDLE);
    assign go       = wr && (sel == OFF_CTRL) && wb.wb_dat_i[CTRL_GO] && !busy;
    // Completion and timeout are only honoured in RUN; done has priority.
    assign fin_done = (state_q == S_RUN) && i2c_done;
    assign fin_tmo  = (state_q == S_RUN) && !i2c_done && (tcnt_q + 32'd1 >= TIMEOUT_CYCLES);

    logic unused_ok;
    assign unused_ok = ^{i2c_busy, wb.wb_dat_i[31:8], wb.wb_adr_i[1:0]};

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (go) state_d = S_HOLD;
            S_HOLD: if (idle_cnt_q + 32'd1 >= MIN_IDLE_CYCLES) state_d = S_RUN;
            S_RUN:  if (fin_done || fin_tmo) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        i2c_start = (state_q != S_RUN);
    end

    // idle_cnt_q counts prior cycles with start high, saturating at the minimum.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q == S_RUN)                    idle_cnt_d = '0;
        else if (idle_cnt_q < MIN_IDLE_CYCLES)   idle_cnt_d = idle_cnt_q + 32'd1;
        tcnt_d = (state_q == S_RUN) ? tcnt_q + 32'd1 : '0;
    end

    always_comb begin
        rw_d   = rw_q;   ie_d   = ie_q;
        addr_d = addr_q; reg_d  = reg_q; tx_d = tx_q; rx_d = rx_q;
        done_d = done_q; nack_d = nack_q; tmo_d = tmo_q;
        if (wr) begin
            case (sel)
                OFF_CTRL: begin
                    ie_d = wb.wb_dat_i[CTRL_IE];
                    if (!busy) rw_d = wb.wb_dat_i[CTRL_RW];
                end
                OFF_ADDR:   if (!busy) addr_d = wb.wb_dat_i[6:0];
                OFF_REG:    if (!busy) reg_d  = wb.wb_dat_i[7:0];
                OFF_TXDATA: if (!busy) tx_d   = wb.wb_dat_i[7:0];
                OFF_STATUS: begin
                    if (wb.wb_dat_i[ST_DONE]) done_d = 1'b0;
                    if (wb.wb_dat_i[ST_NACK]) nack_d = 1'b0;
                    if (wb.wb_dat_i[ST_TMO])  tmo_d  = 1'b0;
                end
                default: ;
            endcase
        end
        // Hardware set comes after the W1C clear so a coincident set wins.
        if (fin_done) begin
            done_d = 1'b1;
            if (!i2c_ack) nack_d = 1'b1;
            if (!rw_q)    rx_d   = i2c_rx_data;
        end
        if (fin_tmo) begin
            done_d = 1'b1;
            tmo_d  = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            OFF_CTRL:   rdata = {29'd0, ie_q, rw_q, 1'b0};
            OFF_ADDR:   rdata = {25'd0, addr_q};
            OFF_REG:    rdata = {24'd0, reg_q};
            OFF_TXDATA: rdata = {24'd0, tx_q};
            OFF_RXDATA: rdata = {24'd0, rx_q};
            OFF_STATUS: rdata = {28'd0, tmo_q, nack_q, done_q, busy};
            default:    rdata = '0;
        endcase
        ack_d = req;
        dat_d = req ? rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q <= 1'b0; ie_q <= 1'b0;
            addr_q <= '0; reg_q <= '0; tx_q <= '0; rx_q <= '0;
            done_q <= 1'b0; nack_q <= 1'b0; tmo_q <= 1'b0;
            idle_cnt_q <= '0; tcnt_q <= '0;
            ack_q <= 1'b0; dat_q <= '0;
        end else begin
            rw_q <= rw_d; ie_q <= ie_d;
            addr_q <= addr_d; reg_q <= reg_d; tx_q <= tx_d; rx_q <= rx_d;
            done_q <= done_d; nack_q <= nack_d; tmo_q <= tmo_d;
            idle_cnt_q <= idle_cnt_d; tcnt_q <= tcnt_d;
            ack_q <= ack_d; dat_q <= dat_d;
        end
    end

    assign wb.wb_ack_o       = ack_q;
    assign wb.wb_dat_o       = dat_q;
    assign i2c_rw            = rw_q;
    assign i2c_slave_address = addr_q;
    assign i2c_slave_reg     = reg_q;
    assign i2c_tx_data       = tx_q;
    assign irq               = ie_q & done_q;

endmodule

// File: tb/tb_wb_i2c_ctrl.sv
// Directed bench for wb_i2c_ctrl: Wishbone reads are scored against a queue
// of expected values; the I2C master is modelled inline by the stimulus.
module tb_wb_i2c_ctrl;
    import wb_i2c_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       i2c_start, i2c_rw, irq;
    logic [6:0] i2c_slave_address;
    logic [7:0] i2c_slave_reg, i2c_tx_data;
    logic       i2c_done, i2c_ack, i2c_busy;
    logic [7:0] i2c_rx_data;

    wb_i2c_ctrl_if wbif();

    wb_i2c_ctrl #(.TIMEOUT_CYCLES(100), .MIN_IDLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .wb(wbif),
        .i2c_start(i2c_start), .i2c_rw(i2c_rw),
        .i2c_slave_address(i2c_slave_address), .i2c_slave_reg(i2c_slave_reg),
        .i2c_tx_data(i2c_tx_data), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
        .i2c_rx_data(i2c_rx_data), .i2c_busy(i2c_busy), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hi_cnt = 0;
    int last_hi = 0;
    logic [31:0] exp_q[$];

    // Length of the most recent run of i2c_start high.
    always @(negedge clk) begin
        if (i2c_start) hi_cnt++;
        else if (hi_cnt != 0) begin last_hi = hi_cnt; hi_cnt = 0; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ra(input logic [2:0] off);
        return {off, 2'b00};
    endfunction

    task automatic wb_write(input logic [2:0] off, input logic [31:0] d);
        int n;
        @(negedge clk);
        wbif.wb_cyc_i = 1; wbif.wb_stb_i = 1; wbif.wb_we_i = 1;
        wbif.wb_adr_i = ra(off); wbif.wb_dat_i = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!wbif.wb_ack_o && n < 8);
        if (!wbif.wb_ack_o) chk("wr_ack", {31'd0, wbif.wb_ack_o}, 32'd1);
        wbif.wb_cyc_i = 0; wbif.wb_stb_i = 0; wbif.wb_we_i = 0;
    endtask

    task automatic wb_read(input logic [2:0] off, input logic [31:0] exp, input string tag);
        int n;
        logic [31:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        wbif.wb_cyc_i = 1; wbif.wb_stb_i = 1; wbif.wb_we_i = 0; wbif.wb_adr_i = ra(off);
        n = 0;
        do begin @(negedge clk); n++; end while (!wbif.wb_ack_o && n < 8);
        e = exp_q.pop_front();
        if (!wbif.wb_ack_o) chk({tag, "_ack"}, {31'd0, wbif.wb_ack_o}, 32'd1);
        else                chk(tag, wbif.wb_dat_o, e);
        wbif.wb_cyc_i = 0; wbif.wb_stb_i = 0;
    endtask

    task automatic wait_low(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (i2c_start && n < 40);
        chk(tag, {31'd0, i2c_start}, 32'd0);
    endtask

    task automatic pulse_done(input logic ack, input logic [7:0] rx);
        @(negedge clk);
        i2c_done = 1; i2c_ack = ack; i2c_rx_data = rx;
        @(negedge clk);
        i2c_done = 0; i2c_ack = 1;
    endtask

    initial begin
        logic [2:0] ackpat;
        int lows;
        reset = 1; i2c_done = 0; i2c_ack = 1; i2c_rx_data = 8'h00; i2c_busy = 0;
        wbif.wb_cyc_i = 0; wbif.wb_stb_i = 0; wbif.wb_we_i = 0;
        wbif.wb_adr_i = '0; wbif.wb_dat_i = '0;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_start", {31'd0, i2c_start}, 32'd1);
        chk("rst_ack",   {31'd0, wbif.wb_ack_o}, 32'd0);
        chk("rst_dat",   wbif.wb_dat_o, 32'd0);
        chk("rst_irq",   {31'd0, irq}, 32'd0);
        chk("rst_outs",  {15'd0, i2c_rw, i2c_slave_address, i2c_slave_reg, i2c_tx_data}, 32'd0);
        wb_read(OFF_STATUS, 32'h0, "rst_status");

        // Held request: ack must never be back-to-back.
        @(negedge clk);
        wbif.wb_cyc_i = 1; wbif.wb_stb_i = 1; wbif.wb_we_i = 0; wbif.wb_adr_i = ra(OFF_ADDR);
        for (int i = 0; i < 3; i++) begin @(negedge clk); ackpat[2-i] = wbif.wb_ack_o; end
        wbif.wb_cyc_i = 0; wbif.wb_stb_i = 0;
        chk("ack_pattern", {29'd0, ackpat}, 32'h5);

        // Write transaction
        wb_write(OFF_ADDR, 32'h48);
        wb_write(OFF_REG, 32'h10);
        wb_write(OFF_TXDATA, 32'hA5);
        wb_write(7, 32'hFF);
        wb_read(OFF_ADDR, 32'h48, "addr_rb");
        wb_read(7, 32'h0, "unmapped_rd");
        wb_write(OFF_CTRL, 32'h3);
        wait_low("wr_start_low");
        chk("wr_outs", {15'd0, i2c_rw, i2c_slave_address, i2c_slave_reg, i2c_tx_data},
            {15'd0, 1'b1, 7'h48, 8'h10, 8'hA5});
        wb_read(OFF_STATUS, 32'h1, "wr_busy");
        pulse_done(1'b1, 8'h00);
        chk("wr_start_back", {31'd0, i2c_start}, 32'd1);

        // Read transaction issued back-to-back: start must still be held high
        wb_write(OFF_CTRL, 32'h1);
        wait_low("rd_start_low");
        @(negedge clk);
        chk("rd_hold_len", {31'd0, last_hi >= 4}, 32'd1);
        chk("rd_rw", {31'd0, i2c_rw}, 32'd0);
        wb_read(OFF_STATUS, 32'h3, "rd_busy_done");
        pulse_done(1'b1, 8'h3C);
        wb_read(OFF_RXDATA, 32'h3C, "rd_rxdata");
        wb_read(OFF_STATUS, 32'h2, "rd_status");
        wb_write(OFF_CTRL, 32'h4);
        chk("irq_set", {31'd0, irq}, 32'd1);
        wb_write(OFF_STATUS, 32'h2);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        wb_read(OFF_STATUS, 32'h0, "rd_w1c");

        // NACK
        wb_write(OFF_CTRL, 32'h1);
        wait_low("nack_start_low");
        pulse_done(1'b0, 8'h3C);
        wb_read(OFF_STATUS, 32'h6, "nack_status");
        wb_write(OFF_STATUS, 32'h6);
        wb_read(OFF_STATUS, 32'h0, "nack_w1c");

        // Timeout after exactly 100 RUN cycles
        i2c_rx_data = 8'h99;
        wb_write(OFF_CTRL, 32'h1);
        wait_low("tmo_start_low");
        repeat (98) @(negedge clk);
        chk("tmo_c99", {31'd0, i2c_start}, 32'd0);
        @(negedge clk);
        chk("tmo_c100", {31'd0, i2c_start}, 32'd0);
        @(negedge clk);
        chk("tmo_idle", {31'd0, i2c_start}, 32'd1);
        wb_read(OFF_STATUS, 32'hA, "tmo_status");
        wb_read(OFF_RXDATA, 32'h3C, "tmo_rxdata");
        wb_write(OFF_STATUS, 32'hA);

        // Busy lockout and stretched done
        wb_write(OFF_CTRL, 32'h1);
        wait_low("lock_start_low");
        wb_write(OFF_TXDATA, 32'hFF);
        wb_write(OFF_CTRL, 32'h1);
        wb_write(OFF_ADDR, 32'h7F);
        chk("lock_tx",   {24'd0, i2c_tx_data}, 32'hA5);
        chk("lock_addr", {25'd0, i2c_slave_address}, 32'h48);
        chk("lock_run",  {31'd0, i2c_start}, 32'd0);
        @(negedge clk);
        i2c_done = 1; i2c_ack = 1; i2c_rx_data = 8'h11;
        @(negedge clk);
        i2c_rx_data = 8'h22;
        repeat (2) @(negedge clk);
        i2c_done = 0;
        lows = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (!i2c_start) lows++; end
        chk("lock_no_retrig", lows, 32'd0);
        wb_read(OFF_RXDATA, 32'h11, "lock_rxdata");
        wb_read(OFF_STATUS, 32'h2, "lock_status");

        // W1C of DONE coinciding with completion: set wins
        wb_write(OFF_CTRL, 32'h1);
        wait_low("w1c_start_low");
        @(negedge clk);
        wbif.wb_cyc_i = 1; wbif.wb_stb_i = 1; wbif.wb_we_i = 1;
        wbif.wb_adr_i = ra(OFF_STATUS); wbif.wb_dat_i = 32'h2;
        i2c_done = 1; i2c_ack = 1;
        @(negedge clk);
        chk("w1c_ack", {31'd0, wbif.wb_ack_o}, 32'd1);
        wbif.wb_cyc_i = 0; wbif.wb_stb_i = 0; wbif.wb_we_i = 0;
        i2c_done = 0;
        wb_read(OFF_STATUS, 32'h2, "w1c_set_wins");

        // Reset in RUN cycle 10
        wb_write(OFF_CTRL, 32'h1);
        wait_low("rst_mid_low");
        repeat (9) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rst_mid_start", {31'd0, i2c_start}, 32'd1);
        wb_read(OFF_STATUS, 32'h0, "rst_mid_status");
        wb_read(OFF_ADDR, 32'h0, "rst_mid_addr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_i2c_ctrl.md
WB_I2C_CTRL -- requirements
Module: wb_i2c_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd200000; max cycles waited for i2c_done before abort.
REQ-002 SHALL have parameter MIN_IDLE_CYCLES, default 4; minimum cycles i2c_start is held high between transactions.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i, inputs, 1 each; Wishbone classic strobe/write.
REQ-006 SHALL have ports wb_adr_i input 5, wb_dat_i input 32, wb_dat_o output 32, wb_ack_o output 1; byte address, word-aligned registers.
REQ-007 SHALL have ports i2c_start output 1, i2c_rw output 1 (1=write, 0=read), i2c_slave_address output 7, i2c_slave_reg output 8, i2c_tx_data output 8; these drive the I2C master.
REQ-008 SHALL have ports i2c_done input 1, i2c_ack input 1, i2c_rx_data input 8, i2c_busy input 1; these are returned by the I2C master.
REQ-009 SHALL have port irq, output 1, level interrupt.

Function
REQ-010 Register map by wb_adr_i[4:2]: 0 CTRL (bit0 GO write-1-pulse, bit1 RW, bit2 IE); 1 ADDR[6:0]; 2 REG[7:0]; 3 TXDATA[7:0]; 4 RXDATA[7:0] RO; 5 STATUS RO/W1C.
REQ-011 STATUS bits SHALL be: bit0 BUSY (RO), bit1 DONE sticky, bit2 NACK sticky, bit3 TIMEOUT sticky; writing 1 to bits1-3 SHALL clear them.
REQ-012 wb_ack_o SHALL assert exactly one cycle, one cycle after a cycle with wb_cyc_i&wb_stb_i&!wb_ack_o; no back-to-back ack.
REQ-013 Reads SHALL return zero-extended register contents on wb_dat_o in the ack cycle; unmapped offsets SHALL read 0 and ignore writes.
REQ-014 Writes to CTRL.RW, ADDR, REG, TXDATA SHALL be ignored while BUSY=1; IE SHALL be writable anytime.
REQ-015 i2c_rw, i2c_slave_address, i2c_slave_reg, i2c_tx_data SHALL be driven continuously from RW/ADDR/REG/TXDATA and stay stable for a whole transaction.
REQ-016 FSM states: IDLE, HOLD, RUN.
REQ-017 IDLE: i2c_start=1 (master parked); GO write -> HOLD, GO while BUSY SHALL be ignored.
REQ-018 HOLD: i2c_start=1 until it has been high for at least MIN_IDLE_CYCLES consecutive cycles since leaving RUN, then -> RUN.
REQ-019 RUN: i2c_start=0, timeout counter increments each cycle.
REQ-020 RUN, first cycle i2c_done=1: RXDATA<=i2c_rx_data only if RW=0; NACK set if i2c_ack=0; DONE set; -> IDLE (i2c_start=1 next cycle).
REQ-021 RUN, counter reaches TIMEOUT_CYCLES with no i2c_done: TIMEOUT and DONE set, RXDATA unchanged, -> IDLE.
REQ-022 i2c_done and timeout in same cycle: done wins, TIMEOUT not set.
REQ-023 W1C of DONE in the same cycle completion sets it: set wins.
REQ-024 BUSY SHALL equal (state != IDLE).
REQ-025 irq SHALL equal IE & DONE.
REQ-026 Further i2c_done cycles after leaving RUN SHALL be ignored.

Reset
REQ-027 On reset: state IDLE, i2c_start=1, wb_ack_o=0, wb_dat_o=0, irq=0, all registers and counters 0, so i2c_rw=0, i2c_slave_address=0, i2c_slave_reg=0, i2c_tx_data=0.
REQ-028 Reset asserted mid-transaction SHALL return to IDLE next cycle with i2c_start=1, discarding the transaction without setting status bits.

Structure
REQ-029 Package wb_i2c_pkg SHALL hold register offsets, CTRL/STATUS bit positions, and FSM state encoding.
REQ-030 Single module; no sub-modules; the I2C master is instantiated alongside it at the next level up.

Verification
REQ-031 Write: ADDR=0x48, REG=0x10, TXDATA=0xA5, CTRL=0x3 -> i2c_start high >=4 cycles then low; outputs 0x48/0x10/0xA5/rw=1; on i2c_done&ack STATUS=0x2, start high next cycle.
REQ-032 Read: CTRL=0x1, model returns i2c_rx_data=0x3C with ack -> RXDATA=0x3C, STATUS=0x2; IE=1 gives irq=1 until STATUS W1C 0x2.
REQ-033 NACK: i2c_done with i2c_ack=0 -> STATUS=0x6; write STATUS=0x6 -> 0x0.
REQ-034 Timeout: TIMEOUT_CYCLES=100, no done -> STATUS=0xA at cycle 100 of RUN, IDLE, RXDATA unchanged.
REQ-035 Busy lockout: during RUN write TXDATA=0xFF and GO -> i2c_tx_data unchanged, no second transaction; done held 3 cycles -> one completion only.
REQ-036 Reset at RUN cycle 10 -> i2c_start=1, STATUS=0x0 next cycle.
